asyn_fifo_write_ctrl_lvl: RTL and testbench

Next-generation write-side controller for the async FIFO, single clock domain (write_clk).
- Synchronises the read-domain Gray pointer internally through a parametrised flop chain.
- Generates the registered Gray write pointer and the RAM write address.
- Adds an occupancy level, a programmable almost-full flag, and a sticky overflow error with clear.
- Sits between the write-side client and the dual-port RAM / read-side controller.

---
 rtl/asyn_fifo_write_ctrl_lvl_if.sv | 28 ++
 rtl/asyn_fifo_write_ctrl_lvl.sv | 87 ++++++++
 tb/tb_asyn_fifo_write_ctrl_lvl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/asyn_fifo_write_ctrl_lvl_if.sv
// Write-side bundle between the FIFO client, the dual-port RAM and the read domain.
// master = client / environment side, slave = write controller.
interface asyn_fifo_write_ctrl_lvl_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  write_ena;
   logic                  clr_overflow;
   logic [ADDR_WIDTH:0]   read_ptr_gray;
   logic [ADDR_WIDTH:0]   write_ptr;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic                  write_accept;
   logic                  write_full;
   logic                  write_almost_full;
   logic [ADDR_WIDTH:0]   write_level;
   logic                  write_overflow;

   modport master (
      output write_ena, clr_overflow, read_ptr_gray,
      input  write_ptr, write_addr, write_accept, write_full,
             write_almost_full, write_level, write_overflow
   );

   modport slave (
      input  write_ena, clr_overflow, read_ptr_gray,
      output write_ptr, write_addr, write_accept, write_full,
             write_almost_full, write_level, write_overflow
   );
endinterface

// File: rtl/asyn_fifo_write_ctrl_lvl.sv
// Async FIFO write-side controller: Gray write pointer, RAM address, full / almost-full,
// pessimistic occupancy level and sticky overflow, with an internal read-pointer synchroniser.
module asyn_fifo_write_ctrl_lvl #(
   parameter int ADDR_WIDTH   = 6,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
   input  logic                          write_clk_i,
   input  logic                          write_rst_i,
   asyn_fifo_write_ctrl_lvl_if.slave     bus
);
   localparam int AW = ADDR_WIDTH;
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
   logic [PW-1:0]                  wbin_q;
   logic [PW-1:0]                  wptr_q;
   logic                           full_q;
   logic                           afull_q;
   logic [PW-1:0]                  level_q;
   logic                           ovf_q;

   logic [PW-1:0] sync_rd_gray_s;
   logic [PW-1:0] sync_rd_bin_s;
   logic          accept_s;
   logic [PW-1:0] wbin_d;
   logic [PW-1:0] wptr_d;
   logic [PW-1:0] level_d;
   logic          full_d;
   logic          afull_d;
   logic          ovf_d;

   // Next-state: pointer advance, occupancy against the synchronised read pointer, flags.
   always_comb begin
      sync_rd_gray_s = sync_q[SYNC_STAGES-1];
      sync_rd_bin_s  = gray2bin(sync_rd_gray_s);
      accept_s       = bus.write_ena & ~full_q;
      wbin_d         = wbin_q + {{AW{1'b0}}, accept_s};
      wptr_d         = (wbin_d >> 1) ^ wbin_d;
      level_d        = wbin_d - sync_rd_bin_s;
      // Full when the write pointer is exactly one lap ahead of the read pointer.
      full_d         = (wptr_d == {~sync_rd_gray_s[AW:AW-1], sync_rd_gray_s[AW-2:0]});
      afull_d        = (level_d >= AFULL_L);
      // Set dominates clear.
      ovf_d          = (bus.write_ena & full_q) | (ovf_q & ~bus.clr_overflow);
   end

   // State registers; synchroniser is reset too so no X leaks from an idle read domain.
   always_ff @(posedge write_clk_i) begin
      if (write_rst_i) begin
         sync_q  <= '0;
         wbin_q  <= '0;
         wptr_q  <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.read_ptr_gray};
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.write_ptr         = wptr_q;
   assign bus.write_addr        = wbin_q[AW-1:0];
   assign bus.write_accept      = accept_s;
   assign bus.write_full        = full_q;
   assign bus.write_almost_full = afull_q;
   assign bus.write_level       = level_q;
   assign bus.write_overflow    = ovf_q;

endmodule

// File: tb/tb_asyn_fifo_write_ctrl_lvl.sv
// Directed bench for the write controller (DEPTH=8, 2 sync stages, almost-full at 6),
// checked each cycle against a count-based occupancy model plus hand-computed values.
module tb_asyn_fifo_write_ctrl_lvl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   asyn_fifo_write_ctrl_lvl_if #(.ADDR_WIDTH(3)) bus ();

   asyn_fifo_write_ctrl_lvl #(
      .ADDR_WIDTH(3), .SYNC_STAGES(2), .AFULL_THRESH(6)
   ) dut (
      .write_clk_i(clk),
      .write_rst_i(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gray(input int v);
      logic [3:0] b;
      b = 4'(v & 15);
      return b ^ (b >> 1);
   endfunction

   // Decode a Gray value by searching the code table.
   function automatic int g2b(input logic [3:0] g);
      for (int b = 0; b < 16; b++) begin
         if (gray(b) == g) return b;
      end
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count of accepted writes, and the read count visible 2 edges later.
   int m_wr = 0, m_lvl = 0;
   bit m_full = 0, m_afull = 0, m_ovf = 0;
   int m_hist [2] = '{0, 0};
   bit m_acc;
   int m_wr_n, m_lvl_n;

   always_comb begin
      m_acc   = bus.write_ena && !m_full;
      m_wr_n  = (m_wr + int'(m_acc)) & 15;
      m_lvl_n = (m_wr_n - m_hist[0]) & 15;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_wr <= 0; m_lvl <= 0; m_full <= 0; m_afull <= 0; m_ovf <= 0;
         m_hist[0] <= 0; m_hist[1] <= 0;
      end else begin
         m_wr      <= m_wr_n;
         m_lvl     <= m_lvl_n;
         m_full    <= (m_lvl_n == 8);
         m_afull   <= (m_lvl_n >= 6);
         m_ovf     <= (bus.write_ena && m_full) || (m_ovf && !bus.clr_overflow);
         m_hist[0] <= m_hist[1];
         m_hist[1] <= g2b(bus.read_ptr_gray);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_ptr",    32'(bus.write_ptr),         32'(gray(m_wr)));
         check("m_addr",   32'(bus.write_addr),        32'(m_wr & 7));
         check("m_accept", 32'(bus.write_accept),      32'(m_acc));
         check("m_full",   32'(bus.write_full),        32'(m_full));
         check("m_afull",  32'(bus.write_almost_full), 32'(m_afull));
         check("m_level",  32'(bus.write_level),       32'(m_lvl));
         check("m_ovf",    32'(bus.write_overflow),    32'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] ptr_seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100};

   initial begin
      int wraps;
      bit full_seen;
      logic [2:0] prev_addr;
      bus.write_ena = 1'b0; bus.clr_overflow = 1'b0; bus.read_ptr_gray = 4'd0;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_ptr",   32'(bus.write_ptr),      32'd0);
      check("rst_level", 32'(bus.write_level),    32'd0);
      check("rst_full",  32'(bus.write_full),     32'd0);
      check("rst_ovf",   32'(bus.write_overflow), 32'd0);

      // Fill 8 entries with no reads.
      for (int k = 0; k < 8; k++) begin
         bus.write_ena = 1'b1;
         check("fill_addr", 32'(bus.write_addr), 32'(k));
         tick();
         check("fill_ptr", 32'(bus.write_ptr), 32'(ptr_seq[k]));
         if (k == 4) check("afull_5", 32'(bus.write_almost_full), 32'd0);
         if (k == 5) check("afull_6", 32'(bus.write_almost_full), 32'd1);
      end
      check("full_8",  32'(bus.write_full),  32'd1);
      check("level_8", 32'(bus.write_level), 32'd8);

      // Overflow while full, then clear.
      check("ovf_accept", 32'(bus.write_accept), 32'd0);
      tick();
      check("ovf_set", 32'(bus.write_overflow), 32'd1);
      check("ovf_ptr", 32'(bus.write_ptr), 32'b1100);
      tick();
      check("ovf_hold", 32'(bus.write_overflow), 32'd1);
      bus.write_ena = 1'b0; bus.clr_overflow = 1'b1;
      tick();
      bus.clr_overflow = 1'b0;
      check("ovf_clr", 32'(bus.write_overflow), 32'd0);

      // Read side advances to 3; full releases on the 3rd edge.
      bus.read_ptr_gray = 4'b0010;
      tick(); check("rel_e1", 32'(bus.write_full), 32'd1);
      tick(); check("rel_e2", 32'(bus.write_full), 32'd1);
      tick(); check("rel_e3", 32'(bus.write_full), 32'd0);
      check("rel_level", 32'(bus.write_level), 32'd5);
      check("rel_afull", 32'(bus.write_almost_full), 32'd0);

      // Streaming with reads trailing by 2.
      bus.read_ptr_gray = gray(6);
      tick(); tick(); tick();
      wraps = 0; full_seen = 0;
      for (int i = 0; i < 20; i++) begin
         bus.write_ena = 1'b1;
         bus.read_ptr_gray = gray(8 + i - 2);
         prev_addr = bus.write_addr;
         tick();
         if (prev_addr == 3'd7 && bus.write_addr == 3'd0) wraps++;
         if (bus.write_full) full_seen = 1;
         if (i == 7) check("ptr_lap", 32'(bus.write_ptr), 32'd0);
      end
      bus.write_ena = 1'b0;
      check("wraps", 32'(wraps), 32'd2);
      check("no_full", 32'(full_seen), 32'd0);

      // Refill to full (28 -> 34 written, 26 read), then set and clear together.
      bus.read_ptr_gray = gray(26);
      for (int i = 0; i < 6; i++) begin
         bus.write_ena = 1'b1;
         tick();
      end
      check("refull", 32'(bus.write_full), 32'd1);
      bus.clr_overflow = 1'b1;
      tick();
      bus.clr_overflow = 1'b0; bus.write_ena = 1'b0;
      check("set_wins", 32'(bus.write_overflow), 32'd1);

      // Drain to level 3, write 2 more, reset mid-burst.
      bus.read_ptr_gray = gray(31);
      tick(); tick(); tick(); tick();
      bus.write_ena = 1'b1;
      tick(); tick();
      check("pre_rst_level", 32'(bus.write_level), 32'd5);
      rst = 1'b1;
      tick();
      check("mrst_ptr",   32'(bus.write_ptr),         32'd0);
      check("mrst_addr",  32'(bus.write_addr),        32'd0);
      check("mrst_level", 32'(bus.write_level),       32'd0);
      check("mrst_full",  32'(bus.write_full),        32'd0);
      check("mrst_afull", 32'(bus.write_almost_full), 32'd0);
      check("mrst_ovf",   32'(bus.write_overflow),    32'd0);
      bus.read_ptr_gray = 4'd0;
      rst = 1'b0;
      check("post_addr", 32'(bus.write_addr), 32'd0);
      check("post_accept", 32'(bus.write_accept), 32'd1);
      tick();
      bus.write_ena = 1'b0;
      check("post_addr1", 32'(bus.write_addr), 32'd1);
      tick(); tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
